// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two datamem requesters, the arbiter and the datamem.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface datamem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    // Port 0: pipeline MEM stage (high priority)
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    // Port 1: debug/DMA loader
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    // Datamem side
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wea;
    logic [DW-1:0] mem_dout;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_raddr, mem_waddr, mem_wdata, mem_wea,
        output mem_dout
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_raddr, mem_waddr, mem_wdata, mem_wea,
        input  mem_dout
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the single-access 256x32 datamem.
// Port 0 has fixed priority; port 1 is force-granted after STARVE_LIMIT
// consecutive denied cycles. Read data returns one cycle after the grant,
// steered to the port that owned the read.
module datamem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 8,
    parameter int DW           = 32
) (
    input  logic              clk,
    input  logic              rst,
    datamem_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [3:0]    starve_cnt_r;
    logic          gnt0_s;
    logic          gnt1_s;
    logic          rd_pend_r;
    logic          rd_owner_r;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic          wea_s;
    logic          rd_grant_s;

    // State register of the priority/force FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= NORMAL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: enter FORCE1 when port 1 is about to be denied one time too many
    always_comb begin
        state_next_s = NORMAL;
        case (state_r)
            NORMAL: begin
                if (bus.p1_req && gnt0_s && (starve_cnt_r == STARVE_MAX)) begin
                    state_next_s = FORCE1;
                end else begin
                    state_next_s = NORMAL;
                end
            end
            FORCE1: begin
                state_next_s = NORMAL;
            end
            default: begin
                state_next_s = NORMAL;
            end
        endcase
    end

    // Grant decode; no grant at all while reset is asserted
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                NORMAL: begin
                    if (bus.p0_req) begin
                        gnt0_s = 1'b1;
                    end else if (bus.p1_req) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b0;
                    end
                end
                FORCE1: begin
                    // Port 1 always holds its request here; the fallback only keeps
                    // the slot useful if it ever does not.
                    if (bus.p1_req) begin
                        gnt1_s = 1'b1;
                    end else if (bus.p0_req) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b0;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.p0_gnt = gnt0_s;
    assign bus.p1_gnt = gnt1_s;

    // Starvation counter: consecutive cycles port 1 waited, saturating at STARVE_MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (bus.p1_req && !gnt1_s) begin
            if (starve_cnt_r < STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= 4'd0;
        end
    end

    // Memory drive: route the granted port to the datamem, idle bus is all zero
    always_comb begin
        addr_s  = {AW{1'b0}};
        wdata_s = {DW{1'b0}};
        wea_s   = 1'b0;
        if (gnt0_s) begin
            addr_s  = bus.p0_addr;
            wdata_s = bus.p0_wdata;
            wea_s   = bus.p0_we;
        end else if (gnt1_s) begin
            addr_s  = bus.p1_addr;
            wdata_s = bus.p1_wdata;
            wea_s   = bus.p1_we;
        end else begin
            addr_s  = {AW{1'b0}};
            wdata_s = {DW{1'b0}};
            wea_s   = 1'b0;
        end
    end

    assign bus.mem_raddr = addr_s;
    assign bus.mem_waddr = addr_s;
    assign bus.mem_wdata = wdata_s;
    assign bus.mem_wea   = wea_s;

    assign rd_grant_s = (gnt0_s && !bus.p0_we) || (gnt1_s && !bus.p1_we);

    // Read tracking: remember that a read is in flight and which port owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else if (rd_grant_s) begin
            rd_pend_r  <= 1'b1;
            rd_owner_r <= gnt1_s;
        end else begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= rd_owner_r;
        end
    end

    // rvalid comes straight from flops; rdata is zero unless the port owns the returning read
    assign bus.p0_rvalid = rd_pend_r & ~rd_owner_r;
    assign bus.p1_rvalid = rd_pend_r &  rd_owner_r;
    assign bus.p0_rdata  = (rd_pend_r && !rd_owner_r) ? bus.mem_dout : {DW{1'b0}};
    assign bus.p1_rdata  = (rd_pend_r &&  rd_owner_r) ? bus.mem_dout : {DW{1'b0}};

endmodule
